// File: rtl/ddr_in_deser.sv
// DDR pad capture on both clk edges, deserialised into W-bit words.
// Word boundary alignment is adjustable one bit at a time via bitslip.
module ddr_in_deser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d,
  input  logic         en,
  input  logic         bitslip,
  output logic         q_rise,
  output logic         q_fall,
  output logic [W-1:0] word,
  output logic         word_vld
);

  localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

  logic          fall_q;
  logic          rise_q;
  logic          qr_q;
  logic          qf_q;
  logic [W-2:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_q, p_d;
  logic          stall_q, stall_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  word_q, word_d;
  logic [W-1:0]  sel;
  logic          wrap;

  // Generic fabric capture; swap for the vendor DDR input cell on FPGA.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) fall_q <= 1'b0;
    else        fall_q <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q  <= 1'b0;
      qr_q    <= 1'b0;
      qf_q    <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      stall_q <= 1'b0;
      vld_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      rise_q  <= d;
      qr_q    <= rise_q;
      qf_q    <= fall_q;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      stall_q <= stall_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
    end
  end

  assign sr_d = {sr_q[W-4:0], qr_q, qf_q};
  assign wrap = en && !stall_q && (cnt_q == LAST);
  assign sel  = p_q ? {sr_q[W-2:0], qr_q}
                    : {sr_q[W-3:0], qr_q, qf_q};

  // A 0->1 slip pushes the boundary into the next pair: hold cnt once.
  always_comb begin
    cnt_d   = cnt_q;
    p_d     = p_q;
    stall_d = stall_q;
    vld_d   = 1'b0;
    word_d  = word_q;
    if (!en) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      stall_d = 1'b0;
      if (!stall_q) cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (wrap) begin
        word_d = sel;
        vld_d  = 1'b1;
      end
      if (bitslip) begin
        p_d     = !p_q;
        stall_d = !p_q;
      end
    end
  end

  assign q_rise   = qr_q;
  assign q_fall   = qf_q;
  assign word     = word_q;
  assign word_vld = vld_q;

endmodule

// File: tb/tb_ddr_in_deser.sv
// Self-checking bench for ddr_in_deser: directed alignment scenarios
// plus randomized traffic against a bit-stream reference model.
module tb_ddr_in_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d = 1'b0;
  logic         en = 1'b0;
  logic         bitslip = 1'b0;
  logic         q_rise;
  logic         q_fall;
  logic [W-1:0] word;
  logic         word_vld;

  always #5 clk = ~clk;

  ddr_in_deser #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .en       (en),
    .bitslip  (bitslip),
    .q_rise   (q_rise),
    .q_fall   (q_fall),
    .word     (word),
    .word_vld (word_vld)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the stream of bits the word logic sees, and the
  // absolute bit index where the next word must end.
  bit           rh [0:1023];
  bit           fh [0:1023];
  int           t;
  bit           m_on;
  bit           m_ph;
  int           m_end;
  logic [W-1:0] m_word;
  bit           m_vld;
  bit           c3;
  int           nst;
  int           st_t;
  logic [W-1:0] st_w;

  function automatic bit sbit(input int i);
    int c;
    c = i / 2;
    if (c < 2) return 1'b0;
    return (i % 2 == 1) ? fh[c-2] : rh[c-2];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    int s;
    s = k % 8;
    if (s == 0) return b;
    return (b << s) | (b >> (8 - s));
  endfunction

  task automatic model_reset();
    t      = 0;
    m_on   = 1'b0;
    m_ph   = 1'b0;
    m_end  = 0;
    m_word = '0;
    m_vld  = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit f, input bit e, input bit s);
    d       = r;
    en      = e;
    bitslip = s;
    @(posedge clk);
    #1;
    rh[t] = r;
    fh[t] = f;
    m_vld = 1'b0;
    if (!e) begin
      m_on = 1'b0;
    end else begin
      if (!m_on) m_end = 2 * (t + W / 2 - 1) + (m_ph ? 0 : 1);
      m_on = 1'b1;
      if (m_end / 2 == t) begin
        for (int i = 0; i < W; i++)
          m_word[W-1-i] = sbit(m_end - W + 1 + i);
        m_vld = 1'b1;
        m_end += W;
      end
      if (s) begin
        m_end += 1;
        m_ph = !m_ph;
      end
    end
    check("word_vld", word_vld, m_vld);
    check("word", word, m_word);
    check("q_rise", q_rise, (t >= 1) ? rh[t-1] : 1'b0);
    check("q_fall", q_fall, (t >= 1) ? fh[t-1] : 1'b0);
    if (word_vld) begin
      nst++;
      st_t = t;
      st_w = word;
    end
    d = f;
    t++;
    @(negedge clk);
    #1;
  endtask

  // Pattern stream: repeating 0xA5 MSB-first, optionally 0x3C at pairs 4..7.
  task automatic step(input bit e, input bit s);
    logic [7:0] b;
    int         idx;
    b   = (c3 && (t / 4) == 1) ? 8'h3C : 8'hA5;
    idx = 2 * (t % 4);
    cyc(b[7-idx], b[6-idx], e, s);
  endtask

  task automatic wait_strobe();
    int c0;
    c0 = nst;
    for (int i = 0; i < 20; i++) begin
      if (nst != c0) break;
      step(1'b1, 1'b0);
    end
    if (nst == c0) check("strobe_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q_rise"}, q_rise, 1'b0);
    check({tag, "_q_fall"}, q_fall, 1'b0);
    check({tag, "_word"}, word, '0);
    check({tag, "_vld"}, word_vld, 1'b0);
  endtask

  initial begin
    int pt;
    int g;
    int n5;
    int nb;
    int e0;

    nst = 0;
    st_t = 0;
    st_w = '0;
    c3 = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      d = 1'b1;
      @(posedge clk);
      #1;
      check_zero("rst");
      d = 1'b0;
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();

    c3 = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    wait_strobe();
    check("first_word", st_w, 8'hA5);
    check("first_time", st_t, 5);
    wait_strobe();
    check("second_word", st_w, 8'h3C);
    check("second_gap", st_t, 9);
    c3 = 1'b0;

    wait_strobe();
    pt = st_t;
    n5 = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      wait_strobe();
      g = st_t - pt;
      pt = st_t;
      check("slip_word", st_w, rotl(8'hA5, k));
      check("slip_gap", g, (k % 2 == 1) ? 5 : 4);
      if (g == 5) n5++;
      wait_strobe();
      g = st_t - pt;
      pt = st_t;
      check("slip_word2", st_w, rotl(8'hA5, k));
      check("slip_gap2", g, 4);
    end
    check("five_cycle_intervals", n5, 4);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("wrap_slip_time", st_t, pt + 4);
    check("wrap_slip_word", st_w, 8'hA5);
    pt = st_t;
    wait_strobe();
    check("after_wrap_word", st_w, 8'h4B);
    check("after_wrap_gap", st_t - pt, 5);

    step(1'b1, 1'b0);
    nb = nst;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("gap_no_vld", nst, nb);
    check("gap_word_held", word, 8'h4B);
    e0 = t;
    wait_strobe();
    check("reenable_time", st_t - e0, 3);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_hold");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    wait_strobe();
    check("post_rst_word", st_w, 8'hA5);
    check("post_rst_time", st_t, 5);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 2), 1'($urandom % 2),
          ($urandom % 8) != 0, ($urandom % 6) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
